// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM.
// Read-during-write policies, sequencer states and lane math.
package ram_pkg;

  localparam int WRITE_FIRST = 0;
  localparam int READ_FIRST  = 1;
  localparam int NO_CHANGE   = 2;

  localparam int LANE_BITS = 9;

  typedef enum logic {
    CLEAR,
    READY
  } ram_state_t;

  function automatic int lanes(input int width);
    return (width + LANE_BITS - 1) / LANE_BITS;
  endfunction

endpackage

// File: rtl/ram_sp_clear_seq.sv
// Zero-fill sequencer: owns the CLEAR/READY FSM and fill counter.
// Its fill port overrides user writes into the array.
module ram_sp_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  ready,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr
);

  localparam logic [ADDR_WIDTH:0] LAST =
    {1'b0, {ADDR_WIDTH{1'b1}}};

  localparam ram_state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  ram_state_t          state;
  logic [ADDR_WIDTH:0] cnt;

  // ready is its own flop so it stays low through reset
  // even when the FSM resets straight into READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
          if (clr && ready) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

  assign fill_we   = (state == CLEAR);
  assign fill_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with 9-bit lanes, RDW policy,
// optional output register and built-in zero-fill.
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 10,
  localparam int BE_WIDTH      = lanes(DATA_WIDTH),
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic                  re,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic IS_WF = (RDW_MODE == WRITE_FIRST);
  localparam logic IS_NC = (RDW_MODE == NO_CHANGE);

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;

  ram_sp_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .ready     (ready),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  // clr outranks a same-cycle user request
  logic accept;
  logic wr;
  logic rd;

  assign accept = ready & ~clr;
  assign wr     = accept & we;
  assign rd     = accept & re & ~(IS_NC & we);

  logic [DATA_WIDTH-1:0] wmask;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_WIDTH; b++)
      wmask[b] = be[b/LANE_BITS];
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [BE_WIDTH-1:0]   mem_be;

  assign mem_we   = fill_we | wr;
  assign mem_addr = fill_we ? fill_addr : addr;
  assign mem_din  = fill_we ? '0 : din;
  assign mem_be   = fill_we ? '1 : be;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q;

  // Array is never reset; the read port is read-first by nature.
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < DATA_WIDTH; b++)
        if (mem_be[b/LANE_BITS])
          mem[mem_addr][b] <= mem_din[b];
    if (rd)
      q <= mem[addr];
  end

  logic                  s1_v;
  logic                  s1_wf;
  logic [DATA_WIDTH-1:0] s1_din;
  logic [DATA_WIDTH-1:0] s1_mask;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_wf   <= 1'b0;
      s1_din  <= '0;
      s1_mask <= '0;
    end else begin
      s1_v  <= rd;
      s1_wf <= rd & we & IS_WF;
      if (rd) begin
        s1_din  <= din;
        s1_mask <= wmask;
      end
    end
  end

  // Write-first merges the registered write onto the old word
  assign s1_data = s1_wf
    ? ((q & ~s1_mask) | (s1_din & s1_mask))
    : q;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        v_q    <= 1'b0;
      end else begin
        v_q <= s1_v;
        if (s1_v)
          dout_q <= s1_data;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = v_q;
  end else begin : g_direct
    logic [DATA_WIDTH-1:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        hold <= '0;
      else if (s1_v)
        hold <= s1_data;
    end

    assign dout       = s1_v ? s1_data : hold;
    assign dout_valid = s1_v;
  end

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port block-RAM macro for the FPGA RAM inference and test flows.
- Generalises the fixed 1024x18 single-port instance to any width and depth, with 9-bit byte-lane write enables, explicit read enable, selectable read-during-write behaviour and an optional output pipeline register.
- Contains a clear sequencer that zero-fills the array after reset or on request, so a known memory state is available without an init file.
- Sits directly under user or test-case top levels wherever a single-port RAM is required.

## Interface
Parameters:
- DATA_WIDTH, 18: word width in bits, 1..72.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH.
- BE_WIDTH, ceil(DATA_WIDTH/9): number of 9-bit write lanes. Derived; not overridden.
- RDW_MODE, 0: read-during-write policy. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 1 adds an output pipeline register.
- CLEAR_ON_RESET, 1: 1 zero-fills the array after reset deassertion.

Ports:
- clk, in, 1: the single clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- clr, in, 1: when high in READY, starts a zero-fill of the array.
- we, in, 1: write request.
- re, in, 1: read request.
- be, in, BE_WIDTH: lane write enables. Lane i covers bits [9i+8:9i]; the top lane may be partial.
- addr, in, ADDR_WIDTH: word address.
- din, in, DATA_WIDTH: write data.
- dout, out, DATA_WIDTH: read data.
- dout_valid, out, 1: one-cycle pulse marking new dout.
- ready, out, 1: high when the block accepts requests.

## Operation
FSM states:
- CLEAR:
  - Entered on reset deassertion if CLEAR_ON_RESET=1, or from READY when clr=1.
  - An internal counter writes 0 to addresses 0..DEPTH-1 at one address per cycle, then moves to READY.
  - ready=0 throughout.
- READY:
  - ready=1.
  - we, re and clr are sampled.
  - Entered directly from reset when CLEAR_ON_RESET=0.

Request handling:
- Requests (we/re) seen while ready=0 are ignored: no write, no dout_valid.
- Write: when we=1 in READY, every lane with be[i]=1 is updated with din. Other lanes keep their contents. be=0 is a legal no-op write.
- Read: when re=1 in READY, the word at addr is returned and dout_valid pulses.
- we=1 and re=1 in the same cycle is resolved by RDW_MODE:
  - WRITE_FIRST: dout shows the merged new word (enabled lanes from din, other lanes old).
  - READ_FIRST: dout shows the pre-write word.
  - NO_CHANGE: the write happens, dout holds its previous value, and dout_valid stays 0.
- dout holds its last value when no read completes.
- clr together with we/re in READY: clr wins, and the we/re request is dropped.
- Reset asserted mid-CLEAR aborts the fill. After release the fill restarts at address 0. Array contents are undefined until the fill completes.
- The array itself is not reset. Only the FSM, the counter, dout, dout_valid and the pipeline stage are reset.

## Timing
Reset values:
- dout = 0 and dout_valid = 0.
- ready = 0 during reset.
- After rst_n rises: ready goes to 1 after DEPTH cycles (CLEAR_ON_RESET=1) or after 1 cycle (CLEAR_ON_RESET=0).

Latency:
- Read latency from the re edge to the dout/dout_valid update is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Back-to-back reads on consecutive cycles produce consecutive dout_valid pulses, one word per cycle.
- A write is visible to a read issued on the next cycle.

Clear:
- A clr sampled in READY drops ready on the next cycle.
- The fill lasts exactly DEPTH cycles, after which ready=1.
- Pipeline contents still in flight when CLEAR starts (OUT_REG=1) are delivered normally.
- The counter is ADDR_WIDTH+1 bits wide so the terminal count at DEPTH does not wrap.

## Structure
- Shared package ram_pkg holds:
  - RDW_MODE constants WRITE_FIRST, READ_FIRST, NO_CHANGE;
  - the FSM state enum {CLEAR, READY};
  - function lanes(width), returning ceil(width/9).
- Sub-module ram_sp_clear_seq holds the CLEAR/READY FSM and the address counter. It drives the internal write mux that sits in front of the array.
- The array is an inferable reg array with a per-lane write loop, so that synthesis maps it to RS_TDP36K.

## Test plan
- Reset then fill: defaults, rst_n released → ready rises after exactly 1024 cycles; a read of address 1023 returns 0 one cycle later.
- Lane write: write 18'h3FFFF at address 5, then be=2'b01 with din=0 → a read returns 18'h3FE00.
- RDW modes: address 7 holds 18'h00AAA; we=re=1 with din=18'h12345, be=2'b11 →
  - mode 0: dout=18'h12345;
  - mode 1: dout=18'h00AAA;
  - mode 2: dout unchanged and no dout_valid, and a following read returns 18'h12345.
- OUT_REG=1: reads of addresses 0..3 on 4 consecutive cycles → four dout_valid pulses starting 2 cycles later, in order.
- Reset mid-clear: rst_n pulsed low at fill cycle 300 → ready stays 0 for 1024 cycles after release, and the fill restarts at address 0.
- Mid-traffic clr: write 18'h15555 at address 9 then assert clr together with re → no dout_valid for that read; after ready returns, address 9 reads 0.
